cargador_operandos: RTL and testbench

//  Upstream feeder for the combinational matrix-vector multiplier.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/contador_slots.sv | 47 ++++
 rtl/cargador_operandos.sv | 142 ++++++++++++++
 tb/tb_cargador_operandos.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the matrix-vector multiplier datapath and its operand loader.
//
// Contents:
//   DEF_BIT / DEF_M / DEF_N  default element width, columns of A (length of x), rows of A
//   TOTAL                    slots per frame for the defaults (N*M matrix + M vector)
//   IDX_W                    slot index width for the defaults
//   state_t                  loader state encoding (LOAD=0, FULL=1)
//   idx_width()              index width for an arbitrary slot count
package mult_pkg;

    localparam int unsigned DEF_BIT = 3;
    localparam int unsigned DEF_M   = 4;
    localparam int unsigned DEF_N   = 2;

    // Index width for a given slot count; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned slots);
        return (slots <= 1) ? 1 : $clog2(slots);
    endfunction

    localparam int unsigned TOTAL = DEF_N * DEF_M + DEF_M;
    localparam int unsigned IDX_W = idx_width(TOTAL);

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/contador_slots.sv
// Slot index counter for the operand loader.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset (clears idx)
//   inc       in   1      advance idx by one
//   load      in   1      synchronous load of load_val (takes priority over inc)
//   load_val  in   Width  value loaded when load is high
//   idx       out  Width  current slot index
//   terminal  out  1      idx is the last slot (Last)
module contador_slots #(
    parameter int unsigned Width = 4,
    parameter int unsigned Last  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic [Width-1:0] idx,
    output logic             terminal
);

    logic [Width-1:0] idx_q;
    logic [Width-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (load) begin
            idx_d = load_val;
        end else if (inc) begin
            idx_d = idx_q + Width'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx      = idx_q;
    assign terminal = (idx_q == Width'(Last));

endmodule

// File: rtl/cargador_operandos.sv
// Operand loader feeding the combinational matrix-vector multiplier.
//
// Collects Bit-wide elements, one per din handshake, into an N*M matrix bus and an M vector
// bus, then holds both stable with ops_valid until the consumer raises ops_ready.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-high reset
//   din        in   Bit      operand element
//   din_valid  in   1        din is valid
//   din_sof    in   1        din is slot 0 of a new frame
//   din_ready  out  1        loader accepts din (registered)
//   mat_a      out  N*M*Bit  packed matrix, slot s at [s*Bit +: Bit] (row s/M, col s%M)
//   vec_x      out  M*Bit    packed vector, element j at [j*Bit +: Bit]
//   ops_valid  out  1        mat_a/vec_x hold a complete frame
//   ops_ready  in   1        consumer takes the frame
//   frame_err  out  1        one-cycle pulse: din_sof accepted mid-frame
module cargador_operandos
    import mult_pkg::*;
#(
    parameter int unsigned Bit = DEF_BIT,
    parameter int unsigned M   = DEF_M,
    parameter int unsigned N   = DEF_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Bit-1:0]   din,
    input  logic             din_valid,
    input  logic             din_sof,
    output logic             din_ready,
    output logic [N*M*Bit-1:0] mat_a,
    output logic [M*Bit-1:0] vec_x,
    output logic             ops_valid,
    input  logic             ops_ready,
    output logic             frame_err
);

    localparam int unsigned NSLOTS   = N * M + M;
    localparam int unsigned IDX_BITS = idx_width(NSLOTS);

    state_t state_q;
    state_t state_d;

    logic                    din_ready_q;
    logic                    frame_err_q;
    logic [NSLOTS*Bit-1:0]   regs_q;
    logic [NSLOTS*Bit-1:0]   regs_d;

    logic [IDX_BITS-1:0]     idx;
    logic                    terminal;
    logic                    accept;
    logic                    resync;
    logic                    cnt_inc;
    logic                    cnt_load;
    logic [IDX_BITS-1:0]     cnt_val;
    logic [IDX_BITS-1:0]     wr_slot;

    // din_ready is a flop, so accept can only happen in LOAD.
    assign accept = din_valid & din_ready_q;
    assign resync = accept & din_sof;

    // A start-of-frame marker always lands in slot 0, abandoning any partial frame.
    assign wr_slot  = resync ? '0 : idx;
    assign cnt_load = accept & (din_sof | terminal);
    assign cnt_val  = din_sof ? IDX_BITS'(1) : '0;
    assign cnt_inc  = accept & ~cnt_load;

    contador_slots #(
        .Width (IDX_BITS),
        .Last  (NSLOTS - 1)
    ) u_contador_slots (
        .clk      (clk),
        .rst      (rst),
        .inc      (cnt_inc),
        .load     (cnt_load),
        .load_val (cnt_val),
        .idx      (idx),
        .terminal (terminal)
    );

    // Operand register file: one write port addressed by wr_slot.
    always_comb begin
        regs_d = regs_q;
        for (int s = 0; s < int'(NSLOTS); s++) begin
            if (accept && (wr_slot == IDX_BITS'(s))) begin
                regs_d[s*Bit +: Bit] = din;
            end
        end
    end

    // FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                // A resync write goes to slot 0, so it never completes a frame.
                if (accept && !din_sof && terminal) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (ops_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        ops_valid = (state_q == FULL);
        din_ready = din_ready_q;
        frame_err = frame_err_q;
        mat_a     = regs_q[N*M*Bit-1:0];
        vec_x     = regs_q[NSLOTS*Bit-1:N*M*Bit];
    end

    // Handshake and data registers. din_ready is held low through reset and rises on the
    // first edge afterwards because it follows the next state rather than the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_ready_q <= 1'b0;
            frame_err_q <= 1'b0;
            regs_q      <= '0;
        end else begin
            din_ready_q <= (state_d == LOAD);
            frame_err_q <= resync & (idx != '0);
            regs_q      <= regs_d;
        end
    end

endmodule

// File: tb/tb_cargador_operandos.sv
// Self-checking bench for cargador_operandos: directed frames plus randomized traffic, all
// compared every cycle against an element-array model of the loader.
module tb_cargador_operandos;

    localparam int Bit   = 3;
    localparam int M     = 4;
    localparam int N     = 2;
    localparam int TOTAL = N * M + M;

    logic                 clk;
    logic                 rst;
    logic [Bit-1:0]       din;
    logic                 din_valid;
    logic                 din_sof;
    logic                 din_ready;
    logic [N*M*Bit-1:0]   mat_a;
    logic [M*Bit-1:0]     vec_x;
    logic                 ops_valid;
    logic                 ops_ready;
    logic                 frame_err;

    cargador_operandos #(
        .Bit (Bit),
        .M   (M),
        .N   (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_sof   (din_sof),
        .din_ready (din_ready),
        .mat_a     (mat_a),
        .vec_x     (vec_x),
        .ops_valid (ops_valid),
        .ops_ready (ops_ready),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the frame as an array of elements, a fill position and a held flag.
    logic [Bit-1:0] m_slot [TOTAL];
    int  m_pos;
    bit  m_held;
    bit  m_rdy;
    bit  m_err;
    bit  m_acc;
    int  err_pulses;

    int t1_data [TOTAL] = '{1, 2, 3, 4, 5, 6, 7, 1, 1, 1, 2, 3};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < TOTAL; s++) m_slot[s] = '0;
        m_pos  = 0;
        m_held = 0;
        m_rdy  = 0;
        m_err  = 0;
        m_acc  = 0;
    endtask

    // One clock edge of the loader's intended behaviour.
    task automatic model_edge();
        m_acc = din_valid && m_rdy;
        m_err = 0;
        if (m_acc) begin
            if (din_sof) begin
                m_err     = (m_pos != 0);
                m_slot[0] = din;
                m_pos     = 1;
            end else begin
                m_slot[m_pos] = din;
                m_pos++;
                if (m_pos == TOTAL) begin
                    m_pos  = 0;
                    m_held = 1;
                end
            end
        end else if (m_held && ops_ready) begin
            m_held = 0;
        end
        m_rdy = !m_held;
    endtask

    task automatic compare_all();
        logic [N*M*Bit-1:0] em;
        logic [M*Bit-1:0]   ex;
        for (int s = 0; s < N * M; s++) em[s*Bit +: Bit] = m_slot[s];
        for (int j = 0; j < M; j++) ex[j*Bit +: Bit] = m_slot[N*M + j];
        chk("ops_valid", 64'(ops_valid), 64'(m_held));
        chk("din_ready", 64'(din_ready), 64'(m_rdy));
        chk("frame_err", 64'(frame_err), 64'(m_err));
        chk("mat_a", 64'(mat_a), 64'(em));
        chk("vec_x", 64'(vec_x), 64'(ex));
        if (frame_err) err_pulses++;
    endtask

    // Drive at the falling edge, let the rising edge act, check at the next falling edge.
    task automatic cycle(input bit v, input bit sof, input logic [Bit-1:0] d, input bit ordy);
        din_valid = v;
        din_sof   = sof;
        din       = d;
        ops_ready = ordy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Offer one element until accepted; bubbles drop din_valid on about half the cycles.
    task automatic feed(input logic [Bit-1:0] d, input bit sof, input bit bubbles,
                        input bit ordy);
        bit done = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            bit v = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle(v, v && sof, d, ordy);
            done = m_acc;
        end
        if (!done) chk("feed_timeout", 64'(0), 64'(1));
    endtask

    task automatic feed_frame1(input bit bubbles, input bit ordy);
        for (int i = 0; i < TOTAL; i++) feed(3'(t1_data[i]), 1'b0, bubbles, ordy);
    endtask

    task automatic check_frame1(input string tag);
        int r0, r1;
        chk({tag, "_valid"}, 64'(ops_valid), 64'(1));
        chk({tag, "_ready"}, 64'(din_ready), 64'(0));
        chk({tag, "_mat"}, 64'(mat_a), 64'(24'o17654321));
        chk({tag, "_vec"}, 64'(vec_x), 64'(12'o3211));
        r0 = 0;
        r1 = 0;
        for (int c = 0; c < M; c++) begin
            r0 += int'(mat_a[c*Bit +: Bit]) * int'(vec_x[c*Bit +: Bit]);
            r1 += int'(mat_a[(M+c)*Bit +: Bit]) * int'(vec_x[c*Bit +: Bit]);
        end
        chk({tag, "_row0"}, 64'(r0), 64'(21));
        chk({tag, "_row1"}, 64'(r1), 64'(28));
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_mat", 64'(mat_a), 64'(0));
        chk("rst_vec", 64'(vec_x), 64'(0));
        chk("rst_valid", 64'(ops_valid), 64'(0));
        chk("rst_ready", 64'(din_ready), 64'(0));
        chk("rst_err", 64'(frame_err), 64'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        din_sof   = 1'b0;
        ops_ready = 1'b0;
        err_pulses = 0;
        model_reset();
        @(negedge clk);
        async_reset();

        // Basic frame: ops_valid in the cycle right after the 12th accept.
        feed_frame1(1'b0, 1'b0);
        check_frame1("t1");

        // Backpressure: nothing is accepted while the frame is held.
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 3'($urandom), 1'b0);
        check_frame1("t2");
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("t2_release_valid", 64'(ops_valid), 64'(0));
        chk("t2_release_ready", 64'(din_ready), 64'(1));

        // Bubbles: same result, same timing relative to the last accept.
        feed_frame1(1'b1, 1'b0);
        check_frame1("t3");
        cycle(1'b0, 1'b0, '0, 1'b1);

        // Resync mid-frame.
        for (int i = 0; i < 5; i++) feed(3'(i + 1), 1'b0, 1'b0, 1'b0);
        err_pulses = 0;
        feed(3'd7, 1'b1, 1'b0, 1'b0);
        chk("t4_err_now", 64'(frame_err), 64'(1));
        for (int i = 0; i < TOTAL - 2; i++) feed(3'(i), 1'b0, 1'b0, 1'b0);
        chk("t4_not_yet", 64'(ops_valid), 64'(0));
        feed(3'd5, 1'b0, 1'b0, 1'b0);
        chk("t4_full", 64'(ops_valid), 64'(1));
        chk("t4_slot0", 64'(mat_a[Bit-1:0]), 64'(7));
        chk("t4_err_pulses", 64'(err_pulses), 64'(1));
        cycle(1'b0, 1'b0, '0, 1'b1);

        // Reset mid-frame, then a clean frame.
        for (int i = 0; i < 6; i++) feed(3'($urandom), 1'b0, 1'b0, 1'b0);
        async_reset();
        feed_frame1(1'b0, 1'b0);
        check_frame1("t5");
        cycle(1'b0, 1'b0, '0, 1'b1);

        // Back-to-back with ops_ready tied high.
        feed_frame1(1'b0, 1'b1);
        check_frame1("t6a");
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("t6_pulse", 64'(ops_valid), 64'(0));
        for (int i = 0; i < TOTAL; i++) feed(3'd7, 1'b0, 1'b0, 1'b1);
        chk("t6b_valid", 64'(ops_valid), 64'(1));
        chk("t6b_mat", 64'(mat_a), 64'(24'o77777777));
        chk("t6b_vec", 64'(vec_x), 64'(12'o7777));
        cycle(1'b0, 1'b0, '0, 1'b1);

        // Random traffic including stray markers and sof without valid.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                  3'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
